// File: rtl/baud_pkg.sv
// Shared constants and helpers for the fractional baud-rate generator.
// Defaults give a 16-bit integer divisor, a 6-bit fraction and 16x oversampling.
package baud_pkg;

    localparam int DEF_INT_W  = 16;
    localparam int DEF_FRAC_W = 6;
    localparam int DEF_OSR    = 16;

    // One extra bit so the largest IBRD plus a fractional carry cannot wrap.
    localparam int DEF_CNT_W  = DEF_INT_W + 1;

    function automatic int cnt_width(input int int_w);
        return int_w + 1;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: shadowed IBRD/FBRD, down-counter and fractional
// accumulator producing the registered oversample tick and a config error flag.
module baud_frac_div
    import baud_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [INT_W-1:0]  ibrd_i,
    input  logic [FRAC_W-1:0] fbrd_i,
    input  logic              load_cfg_i,
    output logic              tick_o,
    output logic              baud16_o,
    output logic              cfg_err_o
);

    localparam int CNT_W = cnt_width(INT_W);

    logic [INT_W-1:0]  ibrd_q, ibrd_d;
    logic [FRAC_W-1:0] fbrd_q, fbrd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] facc_q, facc_d;
    logic              baud16_q, baud16_d;
    logic              cfg_err_q, cfg_err_d;
    logic [FRAC_W:0]   facc_sum;

    always_comb begin
        ibrd_d = ibrd_q;
        fbrd_d = fbrd_q;
        if (!en_i || load_cfg_i) begin
            ibrd_d = ibrd_i;
            fbrd_d = fbrd_i;
        end
        cfg_err_d = (ibrd_d == '0);

        facc_sum = {1'b0, facc_q} + {1'b0, fbrd_q};
        cnt_d    = cnt_q;
        facc_d   = facc_q;
        baud16_d = 1'b0;

        if (!en_i) begin
            cnt_d  = CNT_W'(1);
            facc_d = '0;
        end else if (ibrd_q == '0) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
            // Reload uses the shadow values, so new settings only land here.
            baud16_d = 1'b1;
            facc_d   = facc_sum[FRAC_W-1:0];
            cnt_d    = {1'b0, ibrd_q} + CNT_W'(facc_sum[FRAC_W]);
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ibrd_q    <= '0;
            fbrd_q    <= '0;
            cnt_q     <= CNT_W'(1);
            facc_q    <= '0;
            baud16_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            ibrd_q    <= ibrd_d;
            fbrd_q    <= fbrd_d;
            cnt_q     <= cnt_d;
            facc_q    <= facc_d;
            baud16_q  <= baud16_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign tick_o    = baud16_d;
    assign baud16_o  = baud16_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator top: oversample tick from baud_frac_div plus an
// OSR phase counter producing the bit tick, with Resync to realign bit phase.
module baud_frac_gen
    import baud_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OSR    = DEF_OSR
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   En,
    input  logic [INT_W-1:0]       IBRD,
    input  logic [FRAC_W-1:0]      FBRD,
    input  logic                   LoadCfg,
    input  logic                   Resync,
    output logic                   Baud16,
    output logic                   Baud1,
    output logic [clog2(OSR)-1:0]  Phase,
    output logic                   CfgErr
);

    localparam int PH_W = clog2(OSR);

    logic            tick;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            baud1_q, baud1_d;

    baud_frac_div #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .en_i       (En),
        .ibrd_i     (IBRD),
        .fbrd_i     (FBRD),
        .load_cfg_i (LoadCfg),
        .tick_o     (tick),
        .baud16_o   (Baud16),
        .cfg_err_o  (CfgErr)
    );

    // Phase and Baud1 register on the same decision that registers Baud16,
    // so Baud1 lines up with the OSR-th oversample tick.
    always_comb begin
        phase_d = phase_q;
        baud1_d = 1'b0;
        if (!En || Resync) begin
            phase_d = '0;
        end else if (tick) begin
            if (phase_q == PH_W'(OSR - 1)) begin
                baud1_d = 1'b1;
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= '0;
            baud1_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            baud1_q <= baud1_d;
        end
    end

    assign Phase = phase_q;
    assign Baud1 = baud1_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Directed bench for baud_frac_gen: tick spacing, fractional averaging,
// config shadowing, phase/Baud1 with Resync, and asynchronous reset.
module tb_baud_frac_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] ibrd;
    logic [5:0]  fbrd;
    logic        load_cfg;
    logic        resync;
    logic        baud16;
    logic        baud1;
    logic [3:0]  phase;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    baud_frac_gen #(
        .INT_W  (16),
        .FRAC_W (6),
        .OSR    (16)
    ) dut (
        .CLK     (clk),
        .RESET   (rst),
        .En      (en),
        .IBRD    (ibrd),
        .FBRD    (fbrd),
        .LoadCfg (load_cfg),
        .Resync  (resync),
        .Baud16  (baud16),
        .Baud1   (baud1),
        .Phase   (phase),
        .CfgErr  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Cycles from the current tick negedge to the next Baud16; optional LoadCfg pulse.
    task automatic gap(output int n, input int lc_at);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            load_cfg = (n == lc_at);
            if (baud16 || n >= 300) break;
        end
        load_cfg = 1'b0;
    endtask

    task automatic wait_baud1(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (baud1 || n >= 3000) break;
        end
    endtask

    task automatic count_ticks(input int cycles, output int k);
        k = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (baud16) k++;
        end
    endtask

    // Restart with a new configuration: En low loads the shadows, then En high.
    task automatic restart(input logic [15:0] i, input logic [5:0] f);
        en   = 1'b0;
        ibrd = i;
        fbrd = f;
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int k;
        int sum;
        bit found;

        rst = 1'b1; en = 1'b0; ibrd = 16'd4; fbrd = 6'd0;
        load_cfg = 1'b0; resync = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_baud16", baud16, 0);
        check("rst_baud1", baud1, 0);
        check("rst_phase", phase, 0);
        check("rst_cfgerr", cfg_err, 0);
        rst = 1'b0;

        // IBRD=4, FBRD=0
        restart(16'd4, 6'd0);
        check("ib4_first_tick", baud16, 1);
        check("ib4_phase1", phase, 1);
        check("ib4_cfgerr", cfg_err, 0);
        gap(n, -1);
        check("ib4_gap", n, 4);
        wait_baud1(n);
        check("ib4_baud1_first", n, 56);
        check("ib4_baud1_with_b16", baud16, 1);
        check("ib4_phase_wrap", phase, 0);
        wait_baud1(n);
        check("ib4_baud1_period", n, 64);

        // IBRD=4, FBRD=32: 4,5 alternation, 64 ticks in 288 cycles
        restart(16'd4, 6'd32);
        check("frac_first_tick", baud16, 1);
        gap(n, -1); check("frac_gap0", n, 4);
        gap(n, -1); check("frac_gap1", n, 5);
        gap(n, -1); check("frac_gap2", n, 4);
        gap(n, -1); check("frac_gap3", n, 5);
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            gap(n, -1);
            sum += n;
        end
        check("frac_64_span", sum, 288);

        // IBRD=1: tick every cycle
        restart(16'd1, 6'd0);
        check("ib1_first", baud16, 1);
        count_ticks(20, k);
        check("ib1_every_cycle", k, 20);

        // IBRD=0: config error, no ticks
        en = 1'b0; ibrd = 16'd0; fbrd = 6'd0;
        repeat (2) @(negedge clk);
        check("ib0_cfgerr", cfg_err, 1);
        en = 1'b1;
        count_ticks(100, k);
        check("ib0_no_ticks", k, 0);

        // Shadowing: IBRD=8, change to 3 without then with LoadCfg
        restart(16'd8, 6'd0);
        check("ib8_first", baud16, 1);
        check("ib8_cfgerr_clear", cfg_err, 0);
        gap(n, -1); check("ib8_gap", n, 8);
        ibrd = 16'd3;
        gap(n, -1); check("ib8_no_load_gap", n, 8);
        gap(n, 2);  check("ib8_load_gap", n, 8);
        gap(n, -1); check("ib3_gap_a", n, 3);
        gap(n, -1); check("ib3_gap_b", n, 3);

        // Resync at Phase=9
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (phase == 4'd9) begin
                found = 1'b1;
                break;
            end
        end
        check("rs_find_phase9", found, 1);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        check("rs_phase_cleared", phase, 0);
        k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (baud16) k++;
            if (baud1) break;
        end
        check("rs_ticks_to_baud1", k, 16);

        // Resync coincident with the Phase=15 tick
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (baud16 && phase == 4'd15) begin
                found = 1'b1;
                break;
            end
        end
        check("rs_find_phase15", found, 1);
        repeat (2) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        check("rs_coinc_baud16", baud16, 1);
        check("rs_coinc_baud1", baud1, 0);
        check("rs_coinc_phase", phase, 0);

        // Asynchronous reset mid-run at IBRD=5
        restart(16'd5, 6'd0);
        gap(n, -1);
        check("ib5_gap", n, 5);
        check("ib5_phase_before_rst", phase, 2);
        #1;
        rst = 1'b1;
        en  = 1'b0;
        #1;
        check("async_rst_baud16", baud16, 0);
        check("async_rst_phase", phase, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", baud16, 0);
        en = 1'b1;
        @(negedge clk);
        check("post_rst_first_tick", baud16, 1);
        gap(n, -1);
        check("post_rst_gap", n, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_frac_gen.md
Name: baud_frac_gen

Overview:
Parametrised fractional baud-rate generator that replaces the integer-only Baud16 generator. It divides CLK by IBRD + FBRD/2^FRAC_W to produce the oversample tick Baud16. It also divides Baud16 by OSR to produce a bit-rate tick Baud1, with a resync input so the RX path can realign bit phase on a start edge. It sits between the UART control registers and the Tx/Rx engines.

Parameters:
INT_W, 16, width of integer divisor IBRD and of the down-counter
FRAC_W, 6, width of fractional divisor FBRD; fraction = FBRD/2^FRAC_W
OSR, 16, oversample ratio (Baud16 ticks per Baud1 tick); must be >= 2

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
En  in  1  generator enable; low = idle, counters held at start values
IBRD  in  INT_W  integer divisor
FBRD  in  FRAC_W  fractional divisor
LoadCfg  in  1  one-cycle pulse; captures IBRD/FBRD into shadow registers while En=1
Resync  in  1  one-cycle pulse; clears oversample phase
Baud16  out  1  one-cycle oversample tick, registered
Baud1  out  1  one-cycle bit tick, registered, coincident with every OSR-th Baud16
Phase  out  clog2(OSR)  current oversample phase (0..OSR-1)
CfgErr  out  1  shadow IBRD == 0

Behaviour:
- Reset: Baud16=0, Baud1=0, Phase=0, CfgErr=0. Shadow IBRD=0 and FBRD=0. cnt=1, facc=0.
- Shadow capture: while En=0, shadow registers load IBRD/FBRD every cycle. While En=1, they load only on LoadCfg. A new value takes effect at the next reload, never mid-period.
- CfgErr is registered and equals (shadow IBRD == 0).
- En=0: cnt<=1, facc<=0, Phase<=0, Baud16<=0, Baud1<=0.
- En=1, CfgErr=1: no ticks; cnt held at 1; Baud16=Baud1=0.
- En=1, shadow IBRD>=1, cnt==1 (tick cycle):
  - Baud16<=1.
  - {carry,facc} <= facc + shadow FBRD, computed at FRAC_W+1 bits.
  - cnt <= shadow IBRD + carry, computed at INT_W+1 bits internally.
  - Counter is INT_W+1 bits wide so IBRD = 2^INT_W-1 with carry does not wrap.
- En=1, cnt!=1: Baud16<=0, cnt<=cnt-1.
- First tick: Baud16 is visible on the cycle after the first edge that samples En=1 (cnt starts at 1).
- Period: consecutive Baud16 spacing is IBRD or IBRD+1 cycles. The mean over 2^FRAC_W ticks is exactly IBRD + FBRD/2^FRAC_W.
- IBRD=1, FBRD=0: Baud16 is high every cycle.
- Oversample phase:
  - On a Baud16 tick, Phase<=Phase+1, wrapping OSR-1 -> 0.
  - Baud1<=1 exactly when the tick occurs with Phase==OSR-1; otherwise Baud1<=0.
- Resync: Phase<=0 and Baud1<=0 on the next edge, regardless of any coincident tick. Baud16 is unaffected. facc and cnt are unaffected.
- Resync and LoadCfg together: both act independently.
- Reset mid-period: all state returns to reset values asynchronously. The first tick after release follows the first-tick rule.
- Latency: config capture to effect is at most one full old period.

Decomposition:
- Package baud_pkg:
  - default INT_W/FRAC_W/OSR constants
  - clog2 function
  - localparam for the carry-extended counter width
- One sub-module, baud_frac_div, holds the shadow registers, down-counter, fractional accumulator, Baud16 and CfgErr.
- The top level adds the OSR phase counter, Baud1 and Resync.

Test Plan:
- IBRD=4, FBRD=0, En rises: first Baud16 one cycle after En is sampled, then every 4 cycles. Baud1 on every 16th Baud16, i.e. every 64 cycles.
- IBRD=4, FBRD=32 (FRAC_W=6): Baud16 spacing alternates 4,5,4,5. 64 consecutive ticks span exactly 288 cycles.
- IBRD=1, FBRD=0: Baud16=1 every cycle. IBRD=0: CfgErr=1, no Baud16 for 100 cycles.
- Running at IBRD=8; drive IBRD=3 without LoadCfg: period stays 8. Pulse LoadCfg: the current 8-cycle period completes, then spacing becomes 3.
- Resync pulsed at Phase=9: Phase=0 on the next edge, and the next Baud1 arrives 16 Baud16 ticks later. Resync coincident with Phase=15 tick: Baud16=1, Baud1=0.
- RESET asserted mid-period with IBRD=5: outputs are 0 immediately. After release with En=1, the first Baud16 appears one cycle after En is sampled.
